// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file write port arbiter: MEM/WB pipeline first, md results via a 2-entry queue
module regfile_writeback #(
   parameter int DEPTH = 2,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          mem_valid,
   input  logic          mem_reg_write,
   input  logic          mem_mem_to_reg,
   input  logic [4:0]    mem_write_reg,
   input  logic [DW-1:0] mem_alu_result,
   input  logic [DW-1:0] mem_load_data,
   input  logic          md_valid,
   output logic          md_ready,
   input  logic [4:0]    md_write_reg,
   input  logic [DW-1:0] md_data,
   output logic          regWrite,
   output logic [4:0]    writeReg,
   output logic [DW-1:0] writeData,
   output logic          md_pending,
   output logic          fwd_valid
);

   logic [4:0]    q_reg  [2];
   logic [DW-1:0] q_data [2];
   logic [1:0]    q_live;
   logic          rd_ptr;
   logic          wr_ptr;
   logic [1:0]    count;

   logic p_req;
   logic md_fire;
   logic do_pop;
   logic do_bypass;
   logic do_push;

   always_comb begin
      p_req     = mem_valid && mem_reg_write && (mem_write_reg != 5'd0);
      md_fire   = md_valid && md_ready;
      do_pop    = !p_req && (count != 2'd0);
      do_bypass = !p_req && (count == 2'd0) && md_fire && (md_write_reg != 5'd0);
      do_push   = md_fire && !do_bypass && (md_write_reg != 5'd0);
   end

   assign md_ready   = (count < 2'(DEPTH));
   assign md_pending = (count != 2'd0);
   assign fwd_valid  = regWrite;

   // Write port: a popped entry that was overtaken by a younger pipeline write burns its slot idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regWrite  <= 1'b0;
         writeReg  <= 5'd0;
         writeData <= '0;
      end else if (p_req) begin
         regWrite  <= 1'b1;
         writeReg  <= mem_write_reg;
         writeData <= mem_mem_to_reg ? mem_load_data : mem_alu_result;
      end else if (do_pop) begin
         regWrite <= q_live[rd_ptr];
         if (q_live[rd_ptr]) begin
            writeReg  <= q_reg[rd_ptr];
            writeData <= q_data[rd_ptr];
         end
      end else if (do_bypass) begin
         regWrite  <= 1'b1;
         writeReg  <= md_write_reg;
         writeData <= md_data;
      end else begin
         regWrite <= 1'b0;
      end
   end

   // Queue: invalidate first, then pop/push, so an entry pushed this cycle is never killed by it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_live    <= 2'b00;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         count     <= 2'd0;
         q_reg[0]  <= 5'd0;
         q_reg[1]  <= 5'd0;
         q_data[0] <= '0;
         q_data[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (p_req && q_live[i] && (q_reg[i] == mem_write_reg))
               q_live[i] <= 1'b0;
         end
         if (do_pop) begin
            q_live[rd_ptr] <= 1'b0;
            rd_ptr         <= ~rd_ptr;
         end
         if (do_push) begin
            q_live[wr_ptr] <= 1'b1;
            q_reg[wr_ptr]  <= md_write_reg;
            q_data[wr_ptr] <= md_data;
            wr_ptr         <= ~wr_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed self-checking bench for regfile_writeback
module tb_regfile_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid;
   logic        mem_reg_write;
   logic        mem_mem_to_reg;
   logic [4:0]  mem_write_reg;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_load_data;
   logic        md_valid;
   logic        md_ready;
   logic [4:0]  md_write_reg;
   logic [31:0] md_data;
   logic        regWrite;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic        md_pending;
   logic        fwd_valid;

   int checks = 0;
   int errors = 0;

   regfile_writeback #(.DEPTH(2), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
      .mem_write_reg(mem_write_reg), .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
      .md_valid(md_valid), .md_ready(md_ready), .md_write_reg(md_write_reg), .md_data(md_data),
      .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
      .md_pending(md_pending), .fwd_valid(fwd_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pipe(input logic [4:0] r, input logic m2r, input logic [31:0] alu, input logic [31:0] ld);
      mem_valid = 1'b1; mem_reg_write = 1'b1; mem_write_reg = r;
      mem_mem_to_reg = m2r; mem_alu_result = alu; mem_load_data = ld;
   endtask

   task automatic pipe_idle();
      mem_valid = 1'b0; mem_reg_write = 1'b0; mem_write_reg = 5'd0;
      mem_mem_to_reg = 1'b0; mem_alu_result = 32'd0; mem_load_data = 32'd0;
   endtask

   task automatic md(input logic v, input logic [4:0] r, input logic [31:0] d);
      md_valid = v; md_write_reg = r; md_data = d;
   endtask

   task automatic out(input string tag, input logic rw, input logic [4:0] wr, input logic [31:0] wd);
      check({tag, ".regWrite"}, {31'd0, regWrite}, {31'd0, rw});
      check({tag, ".writeReg"}, {27'd0, writeReg}, {27'd0, wr});
      check({tag, ".writeData"}, writeData, wd);
      check({tag, ".fwd_valid"}, {31'd0, fwd_valid}, {31'd0, rw});
   endtask

   initial begin
      rst_n = 1'b0;
      pipe_idle();
      md(1'b0, 5'd0, 32'd0);
      #3;
      out("reset", 1'b0, 5'd0, 32'd0);
      check("reset.md_pending", {31'd0, md_pending}, 32'd0);
      check("reset.md_ready", {31'd0, md_ready}, 32'd1);
      #10 rst_n = 1'b1;
      tick();

      // pipeline ALU and load selection
      pipe(5'd5, 1'b0, 32'h0000_1234, 32'hFFFF_0000);
      tick();
      out("p_alu", 1'b1, 5'd5, 32'h0000_1234);
      pipe(5'd5, 1'b1, 32'h0000_1111, 32'hDEAD_BEEF);
      tick();
      out("p_load", 1'b1, 5'd5, 32'hDEAD_BEEF);
      pipe_idle();
      tick();
      out("idle_hold", 1'b0, 5'd5, 32'hDEAD_BEEF);

      // md bypass
      md(1'b1, 5'd7, 32'h55);
      #1 check("bypass.md_ready", {31'd0, md_ready}, 32'd1);
      tick();
      md(1'b0, 5'd0, 32'd0);
      out("bypass", 1'b1, 5'd7, 32'h55);
      check("bypass.md_pending", {31'd0, md_pending}, 32'd0);

      // fill queue under pipeline pressure, then drain in order
      pipe(5'd1, 1'b0, 32'h11, 32'd0); md(1'b1, 5'd8, 32'd1);
      tick();
      out("fillA", 1'b1, 5'd1, 32'h11);
      check("fillA.md_pending", {31'd0, md_pending}, 32'd1);
      check("fillA.md_ready", {31'd0, md_ready}, 32'd1);
      pipe(5'd2, 1'b0, 32'h22, 32'd0); md(1'b1, 5'd9, 32'd2);
      tick();
      out("fillB", 1'b1, 5'd2, 32'h22);
      check("fillB.md_ready", {31'd0, md_ready}, 32'd0);
      pipe(5'd3, 1'b0, 32'h33, 32'd0); md(1'b1, 5'd10, 32'd3);
      #1 check("fillC.md_ready", {31'd0, md_ready}, 32'd0);
      tick();
      out("fillC", 1'b1, 5'd3, 32'h33);
      pipe_idle();
      tick();
      out("drain8", 1'b1, 5'd8, 32'd1);
      check("drain8.md_ready", {31'd0, md_ready}, 32'd1);
      tick();
      md(1'b0, 5'd0, 32'd0);
      out("drain9", 1'b1, 5'd9, 32'd2);
      check("drain9.md_pending", {31'd0, md_pending}, 32'd1);
      tick();
      out("drain10", 1'b1, 5'd10, 32'd3);
      check("drain10.md_pending", {31'd0, md_pending}, 32'd0);
      tick();
      out("drained", 1'b0, 5'd10, 32'd3);

      // asynchronous reset with two queued entries
      pipe(5'd1, 1'b0, 32'hA1, 32'd0); md(1'b1, 5'd11, 32'h111);
      tick();
      pipe(5'd2, 1'b0, 32'hA2, 32'd0); md(1'b1, 5'd12, 32'h222);
      tick();
      pipe_idle(); md(1'b0, 5'd0, 32'd0);
      check("prerst.md_ready", {31'd0, md_ready}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      out("midrst", 1'b0, 5'd0, 32'd0);
      check("midrst.md_pending", {31'd0, md_pending}, 32'd0);
      check("midrst.md_ready", {31'd0, md_ready}, 32'd1);
      #2 rst_n = 1'b1;
      tick();
      out("postrst", 1'b0, 5'd0, 32'd0);
      check("postrst.md_pending", {31'd0, md_pending}, 32'd0);

      // younger pipeline write kills the queued entry to the same register
      pipe(5'd1, 1'b0, 32'h1, 32'd0); md(1'b1, 5'd8, 32'hAA);
      tick();
      out("conf_q", 1'b1, 5'd1, 32'h1);
      pipe(5'd8, 1'b0, 32'hBB, 32'd0); md(1'b0, 5'd0, 32'd0);
      tick();
      out("conf_p", 1'b1, 5'd8, 32'hBB);
      check("conf_p.md_pending", {31'd0, md_pending}, 32'd1);
      pipe_idle();
      tick();
      out("conf_drop", 1'b0, 5'd8, 32'hBB);
      check("conf_drop.md_pending", {31'd0, md_pending}, 32'd0);

      // r0 writes from either source are never issued
      pipe(5'd0, 1'b0, 32'h99, 32'd0);
      tick();
      out("p_r0", 1'b0, 5'd8, 32'hBB);
      pipe_idle();
      mem_reg_write = 1'b1; mem_write_reg = 5'd4; mem_alu_result = 32'h44;
      tick();
      out("p_novalid", 1'b0, 5'd8, 32'hBB);
      pipe_idle(); md(1'b1, 5'd0, 32'h77);
      #1 check("md_r0.md_ready", {31'd0, md_ready}, 32'd1);
      tick();
      md(1'b0, 5'd0, 32'd0);
      out("md_r0", 1'b0, 5'd8, 32'hBB);
      check("md_r0.md_pending", {31'd0, md_pending}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-back stage that drives the register file's write port (writeReg, writeData, regWrite).
- Merges two sources: the in-order MEM/WB pipeline result and results returned by the multi-cycle multiply/divide unit (md).
- The pipeline always has priority. md results wait in a 2-entry queue and drain into free write slots.
- Also exports the current write as a forwarding source for the EX-stage bypass logic.

Parameters:
- DEPTH, 2, md result queue entries (fixed 2; not required to scale).
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- mem_valid  in  1  MEM stage holds a valid instruction this cycle.
- mem_reg_write  in  1  instruction writes a GPR.
- mem_mem_to_reg  in  1  1: write mem_load_data; 0: write mem_alu_result.
- mem_write_reg  in  5  destination GPR.
- mem_alu_result  in  DW  ALU result.
- mem_load_data  in  DW  load data.
- md_valid  in  1  md unit offers a result.
- md_ready  out  1  queue can accept; transfer when md_valid && md_ready.
- md_write_reg  in  5  md destination GPR.
- md_data  in  DW  md result.
- regWrite  out  1  register file write enable.
- writeReg  out  5  register file write address.
- writeData  out  DW  register file write data.
- md_pending  out  1  queue non-empty.
- fwd_valid  out  1  equals regWrite (forwarding tap).

Behaviour:
- Reset (async, rst_n=0): regWrite=0, writeReg=0, writeData=0, queue empty, md_pending=0, md_ready=1, fwd_valid=0.
- Pipeline request: p_req = mem_valid && mem_reg_write && mem_write_reg!=0. A write to r0 is never issued and does not occupy the slot.
- Per-cycle posedge selection, in priority order:
  1. p_req: output regs <= {1, mem_write_reg, mem_to_reg ? load : alu}.
  2. Else queue non-empty: output regs <= queue head; pop.
  3. Else md fire with md_write_reg!=0: output regs <= md result directly (bypass; no enqueue).
  4. Else: regWrite <= 0; writeReg/writeData hold their previous values.
- Enqueue: md fire not consumed by bypass and md_write_reg!=0 -> push to queue tail.
- md fire with md_write_reg==0: accepted and discarded.
- md_ready = queue count < DEPTH, combinational from registered count.
  - Full queue: md_ready=0.
  - Simultaneous pop and push when full is not possible, since md_ready was already 0.
- Pop and push in the same cycle: count unchanged; FIFO order preserved.
- Latency:
  - Pipeline input -> regWrite asserted the next cycle; register file commits at the following negedge.
  - md bypass: same as pipeline.
  - Queued entries: one entry per free slot, in order.
- Ordering conflict: p_req && mem_write_reg equals the register of a queued entry -> that entry is invalidated (the younger pipeline write wins).
  - Invalidated entries are popped without writing; the pop still consumes a slot cycle, with regWrite=0.
  - If md fires to the same register as a p_req in the same cycle, the md result is still enqueued; issue logic guarantees md results are older.
- Queue: 2-entry circular buffer. Pointers are 1 bit wide and wrap 1->0. Count is 0..2.
- Reset mid-operation clears the queue; queued md results are lost, and issue logic must re-issue.
- md_pending = count!=0. fwd_valid = regWrite.

Test Plan:
- Reset with the queue holding 2 entries -> regWrite=0, md_pending=0, md_ready=1 immediately, asynchronously.
- Pipeline write to r5, alu=0x0000_1234, mem_to_reg=0 -> next cycle regWrite=1, writeReg=5, writeData=0x1234.
- Same pipeline write with mem_to_reg=1, load=0xDEAD_BEEF -> writeData=0xDEADBEEF.
- md result r7=0x55 with no pipeline write -> bypass; next cycle regWrite=1, writeReg=7, writeData=0x55, md_pending stays 0.
- Pipeline writes every cycle while md sends r8=1, r9=2, then r10=3:
  - r8 and r9 are accepted; md_ready=0 on the r10 attempt.
  - The pipeline then idles 3 cycles -> writes r8=1, r9=2, then r10=3, in order.
- Queue holds r8=0xAA while the pipeline writes r8=0xBB -> r8 written 0xBB; the queued entry is dropped, giving an idle slot with regWrite=0. Pipeline or md write to r0 -> regWrite stays 0.
